// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared encodings for the pipeline sequencing controller.
//   - StallBus (5:0): bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold.
//   - STALL_NONE / STALL_ID / STALL_EX stall vector encodings.
//   - Controller state codes PC_RUN / PC_MC_BUSY / PC_FLUSH.
//   - Default general-exception vector.
package pipe_ctrl_pkg;

    typedef logic [5:0] stall_bus_t;

    localparam stall_bus_t STALL_NONE = 6'b000000;
    // PC/IF/ID hold; id_ex inserts a bubble into EX.
    localparam stall_bus_t STALL_ID   = 6'b000111;
    // PC/IF/ID/EX hold; ex_mem inserts a bubble into MEM.
    localparam stall_bus_t STALL_EX   = 6'b001111;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;

    typedef enum logic [1:0] {
        PC_RUN     = 2'd0,
        PC_MC_BUSY = 2'd1,
        PC_FLUSH   = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: request/response bundle between the pipeline stages and
// pipe_ctrl.
//   master (pipeline side): drives stallreq_id, ex_mc_start, ex_mc_len,
//                           excp_valid, excp_eret, epc; reads stall, flush,
//                           new_pc, perf_stall_cnt.
//   slave  (pipe_ctrl):     the mirror image.
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_LEN_W = 6
);
    logic                stallreq_id;
    logic                ex_mc_start;
    logic [MC_LEN_W-1:0] ex_mc_len;
    logic                excp_valid;
    logic                excp_eret;
    logic [31:0]         epc;
    stall_bus_t          stall;
    logic                flush;
    logic [31:0]         new_pc;
    logic [31:0]         perf_stall_cnt;

    modport master (
        output stallreq_id, ex_mc_start, ex_mc_len, excp_valid, excp_eret, epc,
        input  stall, flush, new_pc, perf_stall_cnt
    );

    modport slave (
        input  stallreq_id, ex_mc_start, ex_mc_len, excp_valid, excp_eret, epc,
        output stall, flush, new_pc, perf_stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl_perf.sv
// pipe_ctrl_perf: saturating 32-bit stall-cycle counter.
// Only compiled when PIPE_CTRL_PERF_EN is defined, which is also the only
// build in which pipe_ctrl instantiates it.
// Ports:
//   clk  in   clock
//   rst  in   asynchronous active-low reset, clears the count
//   inc  in   count this cycle
//   cnt  out  current count, sticks at 32'hFFFF_FFFF
`ifdef PIPE_CTRL_PERF_EN
module pipe_ctrl_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] cnt
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (inc && (cnt != 32'hFFFF_FFFF))
            cnt <= cnt + 32'd1;
    end
endmodule
`endif

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the five-stage MIPS32 core.
// Single owner of freeze/kill decisions: merges the ID load-use stall and the
// EX multi-cycle stall into one stall vector, and issues a one-cycle flush
// with a redirect PC on exceptions and ERET.
//
// Parameters:
//   EXC_VECTOR  PC loaded on a general exception
//   MC_LEN_W    width of the multi-cycle length field
// Ports:
//   clk  in   pipeline clock
//   rst  in   asynchronous active-low reset
//   bus  slave side of pipe_ctrl_if:
//        stallreq_id, ex_mc_start, ex_mc_len, excp_valid, excp_eret, epc  in
//        stall (combinational), flush, new_pc (registered), perf_stall_cnt out
// Build option:
//   PIPE_CTRL_PERF_EN  when defined, perf_stall_cnt counts stalled cycles;
//                      otherwise it is tied to zero.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter int          MC_LEN_W   = 6
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);

    localparam logic [MC_LEN_W-1:0] LEN_ONE = MC_LEN_W'(1);

    pc_state_e           state_q, state_d;
    logic [MC_LEN_W-1:0] cnt_q, cnt_d;
    logic [31:0]         pc_q, pc_d;
    stall_bus_t          stall_c;
    logic [31:0]         perf_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PC_RUN;
            cnt_q   <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        stall_c = STALL_NONE;

        if (bus.excp_valid) begin
            // Exception wins in every state, including FLUSH: the faulting
            // instruction must not be frozen, and any multi-cycle op is dropped.
            state_d = PC_FLUSH;
            cnt_d   = '0;
            pc_d    = bus.excp_eret ? bus.epc : EXC_VECTOR;
        end else begin
            unique case (state_q)
                PC_RUN: begin
                    // Zero-length ops are ignored so a load-use stall may still apply.
                    if (bus.ex_mc_start && (bus.ex_mc_len != '0)) begin
                        stall_c = STALL_EX;
                        // The start cycle is the first stall cycle; the rest run in MC_BUSY.
                        if (bus.ex_mc_len != LEN_ONE) begin
                            cnt_d   = bus.ex_mc_len - LEN_ONE;
                            state_d = PC_MC_BUSY;
                        end
                    end else if (bus.stallreq_id) begin
                        stall_c = STALL_ID;
                    end
                end
                PC_MC_BUSY: begin
                    stall_c = STALL_EX;
                    cnt_d   = cnt_q - LEN_ONE;
                    // <= rather than == so a corrupted zero count cannot lock up.
                    if (cnt_q <= LEN_ONE) begin
                        cnt_d   = '0;
                        state_d = PC_RUN;
                    end
                end
                PC_FLUSH: begin
                    // Requests this cycle come from killed instructions.
                    state_d = PC_RUN;
                end
                default: begin
                    state_d = PC_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign bus.stall  = stall_c;
    assign bus.flush  = (state_q == PC_FLUSH);
    assign bus.new_pc = pc_q;

`ifdef PIPE_CTRL_PERF_EN
    pipe_ctrl_perf u_perf (
        .clk (clk),
        .rst (rst),
        .inc (stall_c != STALL_NONE),
        .cnt (perf_cnt)
    );
`else
    assign perf_cnt = 32'h0;
`endif

    assign bus.perf_stall_cnt = perf_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
// Inputs change at the falling edge; outputs are sampled 1 ns later, well
// before the next rising edge.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.MC_LEN_W(6)) bus ();

    pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .MC_LEN_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [31:0] PERF_EXP = 32'd5;
`else
    localparam logic [31:0] PERF_EXP = 32'd0;
`endif

    // Advance to the next falling edge (one full cycle).
    task automatic next_cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.stallreq_id = 1'b0;
        bus.ex_mc_start = 1'b0;
        bus.ex_mc_len   = 6'd0;
        bus.excp_valid  = 1'b0;
        bus.excp_eret   = 1'b0;
        bus.epc         = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #2;
        n_chk++; if (bus.stall !== 6'b000000) begin n_fail++; $display("FAIL reset_stall got=%b exp=000000", bus.stall); end
        n_chk++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got=%b exp=0", bus.flush); end
        n_chk++; if (bus.new_pc !== 32'h0) begin n_fail++; $display("FAIL reset_new_pc got=%h exp=0", bus.new_pc); end
        n_chk++; if (bus.perf_stall_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_perf got=%0d exp=0", bus.perf_stall_cnt); end
        @(negedge clk);
        rst = 1'b1;
        next_cyc();
    endtask

    task automatic test_id_stall();
        bus.stallreq_id = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_chk++; if (bus.stall !== 6'b000111) begin n_fail++; $display("FAIL id_stall[%0d] got=%b exp=000111", i, bus.stall); end
            next_cyc();
        end
        bus.stallreq_id = 1'b0;
        #1;
        n_chk++; if (bus.stall !== 6'b000000) begin n_fail++; $display("FAIL id_release got=%b exp=000000", bus.stall); end
        next_cyc();
    endtask

    task automatic test_mc_len5();
        bus.stallreq_id = 1'b1;
        bus.ex_mc_start = 1'b1;
        bus.ex_mc_len   = 6'd5;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_chk++; if (bus.stall !== 6'b001111) begin n_fail++; $display("FAIL mc5_stall[%0d] got=%b exp=001111", i, bus.stall); end
            next_cyc();
            bus.ex_mc_start = 1'b0;
        end
        #1;
        n_chk++; if (bus.stall !== 6'b000111) begin n_fail++; $display("FAIL mc5_after got=%b exp=000111", bus.stall); end
        next_cyc();
        idle_inputs();
        next_cyc();
    endtask

    task automatic test_mc_short();
        // len=0 is ignored: no stall alone, ID stall still honoured.
        bus.ex_mc_start = 1'b1;
        bus.ex_mc_len   = 6'd0;
        #1;
        n_chk++; if (bus.stall !== 6'b000000) begin n_fail++; $display("FAIL mc0_none got=%b exp=000000", bus.stall); end
        bus.stallreq_id = 1'b1;
        #1;
        n_chk++; if (bus.stall !== 6'b000111) begin n_fail++; $display("FAIL mc0_id got=%b exp=000111", bus.stall); end
        next_cyc();
        // len=1: one EX cycle, stays in RUN.
        bus.stallreq_id = 1'b0;
        bus.ex_mc_len   = 6'd1;
        #1;
        n_chk++; if (bus.stall !== 6'b001111) begin n_fail++; $display("FAIL mc1_stall got=%b exp=001111", bus.stall); end
        next_cyc();
        bus.ex_mc_start = 1'b0;
        #1;
        n_chk++; if (bus.stall !== 6'b000000) begin n_fail++; $display("FAIL mc1_after got=%b exp=000000", bus.stall); end
        next_cyc();
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_s [5];
        exp_s = '{6'b001111, 6'b001111, 6'b001111, 6'b001111, 6'b000000};
        for (int i = 0; i < 5; i++) begin
            bus.ex_mc_start = (i == 0) || (i == 2);
            bus.ex_mc_len   = 6'd2;
            #1;
            n_chk++; if (bus.stall !== exp_s[i]) begin n_fail++; $display("FAIL b2b_stall[%0d] got=%b exp=%b", i, bus.stall, exp_s[i]); end
            next_cyc();
        end
        idle_inputs();
    endtask

    task automatic test_exception();
        bus.ex_mc_start = 1'b1;
        bus.ex_mc_len   = 6'd8;
        next_cyc();
        bus.ex_mc_start = 1'b0;
        next_cyc();
        bus.excp_valid = 1'b1;
        bus.excp_eret  = 1'b0;
        bus.epc        = 32'hDEAD_BEEF;
        #1;
        n_chk++; if (bus.stall !== 6'b000000) begin n_fail++; $display("FAIL exc_stall got=%b exp=000000", bus.stall); end
        n_chk++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL exc_flush_early got=%b exp=0", bus.flush); end
        next_cyc();
        // FLUSH cycle: requests from killed instructions must be ignored.
        bus.excp_valid  = 1'b0;
        bus.stallreq_id = 1'b1;
        bus.ex_mc_start = 1'b1;
        bus.ex_mc_len   = 6'd3;
        #1;
        n_chk++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL exc_flush got=%b exp=1", bus.flush); end
        n_chk++; if (bus.new_pc !== 32'h0000_0020) begin n_fail++; $display("FAIL exc_new_pc got=%h exp=00000020", bus.new_pc); end
        n_chk++; if (bus.stall !== 6'b000000) begin n_fail++; $display("FAIL exc_flush_stall got=%b exp=000000", bus.stall); end
        next_cyc();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            #1;
            n_chk++; if (bus.stall !== 6'b000000) begin n_fail++; $display("FAIL exc_after_stall[%0d] got=%b exp=000000", i, bus.stall); end
            n_chk++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL exc_after_flush[%0d] got=%b exp=0", i, bus.flush); end
            next_cyc();
        end
    endtask

    task automatic test_eret_repeat();
        bus.excp_valid = 1'b1;
        bus.excp_eret  = 1'b1;
        bus.epc        = 32'h0000_1234;
        next_cyc();
        bus.epc = 32'h0000_5678;
        #1;
        n_chk++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL eret1_flush got=%b exp=1", bus.flush); end
        n_chk++; if (bus.new_pc !== 32'h0000_1234) begin n_fail++; $display("FAIL eret1_new_pc got=%h exp=00001234", bus.new_pc); end
        next_cyc();
        idle_inputs();
        #1;
        n_chk++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL eret2_flush got=%b exp=1", bus.flush); end
        n_chk++; if (bus.new_pc !== 32'h0000_5678) begin n_fail++; $display("FAIL eret2_new_pc got=%h exp=00005678", bus.new_pc); end
        next_cyc();
        #1;
        n_chk++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL eret_done_flush got=%b exp=0", bus.flush); end
        next_cyc();
    endtask

    task automatic test_reset_mid_busy();
        bus.ex_mc_start = 1'b1;
        bus.ex_mc_len   = 6'd10;
        next_cyc();
        bus.ex_mc_start = 1'b0;
        for (int i = 1; i < 4; i++) next_cyc();
        #1;
        n_chk++; if (bus.stall !== 6'b001111) begin n_fail++; $display("FAIL rstbusy_pre got=%b exp=001111", bus.stall); end
        rst = 1'b0;
        #1;
        n_chk++; if (bus.stall !== 6'b000000) begin n_fail++; $display("FAIL rstbusy_stall got=%b exp=000000", bus.stall); end
        n_chk++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL rstbusy_flush got=%b exp=0", bus.flush); end
        n_chk++; if (bus.new_pc !== 32'h0) begin n_fail++; $display("FAIL rstbusy_new_pc got=%h exp=0", bus.new_pc); end
        n_chk++; if (bus.perf_stall_cnt !== 32'h0) begin n_fail++; $display("FAIL rstbusy_perf got=%0d exp=0", bus.perf_stall_cnt); end
        next_cyc();
        rst = 1'b1;
        next_cyc();
        #1;
        n_chk++; if (bus.stall !== 6'b000000) begin n_fail++; $display("FAIL rstbusy_run got=%b exp=000000", bus.stall); end
        bus.stallreq_id = 1'b1;
        #1;
        n_chk++; if (bus.stall !== 6'b000111) begin n_fail++; $display("FAIL rstbusy_run_id got=%b exp=000111", bus.stall); end
        bus.stallreq_id = 1'b0;
        next_cyc();
    endtask

    // Run from a fresh reset so only this scenario's stalls are counted.
    task automatic test_perf();
        rst = 1'b0;
        next_cyc();
        rst = 1'b1;
        next_cyc();
        bus.ex_mc_start = 1'b1;
        bus.ex_mc_len   = 6'd3;
        next_cyc();
        bus.ex_mc_start = 1'b0;
        next_cyc();
        next_cyc();
        bus.stallreq_id = 1'b1;
        next_cyc();
        next_cyc();
        bus.stallreq_id = 1'b0;
        bus.excp_valid  = 1'b1;
        #1;
        n_chk++; if (bus.perf_stall_cnt !== PERF_EXP) begin n_fail++; $display("FAIL perf_pre_exc got=%0d exp=%0d", bus.perf_stall_cnt, PERF_EXP); end
        next_cyc();
        bus.excp_valid = 1'b0;
        next_cyc();
        next_cyc();
        #1;
        n_chk++; if (bus.perf_stall_cnt !== PERF_EXP) begin n_fail++; $display("FAIL perf_total got=%0d exp=%0d", bus.perf_stall_cnt, PERF_EXP); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_id_stall();
        test_mc_len5();
        test_mc_short();
        test_back_to_back();
        test_exception();
        test_eret_repeat();
        test_reset_mid_busy();
        test_perf();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
